// File: rtl/hazard_pipe_ctrl_if.sv
// Bypass/hazard bundle between the 5-stage core and hazard_pipe_ctrl.
// stall_cycles exists only when HAZ_STALL_CNT_EN is defined.
interface hazard_pipe_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] if_id_rs1;
  logic [REG_AW-1:0] if_id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              branch_taken;
  logic              mem_ready;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              mem_req;
  logic [REG_AW-1:0] id_ex_rd;
  logic              id_ex_memread;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_regwrite;
  logic [REG_AW-1:0] mem_wb_rd;
  logic              mem_wb_regwrite;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
`endif

  modport master (
    input  if_id_rs1, if_id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
           branch_taken, mem_ready,
    output pc_write, if_id_write, if_id_flush, mem_req, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite
`ifdef HAZ_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output if_id_rs1, if_id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
           branch_taken, mem_ready,
    input  pc_write, if_id_write, if_id_flush, mem_req, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite
`ifdef HAZ_STALL_CNT_EN
    , input stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Hazard/bypass pipeline controller: carries rd metadata ID->EX->MEM->WB, load-use stall,
// branch flush and data-memory freeze. Optional stall counter under HAZ_STALL_CNT_EN.
//
// state   | meaning
// ST_RUN  | pipe advances; load-use stalls and branch flushes resolved combinationally
// ST_WAIT | data-memory access outstanding, every stage register held
module hazard_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_pipe_ctrl_if.master bus
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } stage_t;

  state_t state, state_nxt;
  stage_t id_stage, id_ex, ex_mem, mem_wb;

  logic memop, freeze, load_use;
  logic advance, bubble;
  logic pc_write, if_id_write, if_id_flush;

  assign id_stage = '{rd: bus.id_rd, regwrite: bus.id_regwrite,
                      memread: bus.id_memread, memwrite: bus.id_memwrite};

  always_comb begin
    memop       = ex_mem.memread | ex_mem.memwrite;
    freeze      = memop & ~bus.mem_ready;
    load_use    = id_ex.memread & (id_ex.rd != '0) &
                  ((id_ex.rd == bus.if_id_rs1) | (id_ex.rd == bus.if_id_rs2));
    state_nxt   = state;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    advance     = 1'b1;
    bubble      = 1'b0;

    case (state)
      ST_RUN:  if (freeze) state_nxt = ST_WAIT;
      ST_WAIT: if (bus.mem_ready) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase

    // A held EX stage means a pending branch is simply seen again after release.
    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      advance     = 1'b0;
    end else if (bus.branch_taken) begin
      if_id_flush = 1'b1;
      bubble      = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        id_ex  <= bubble ? '0 : id_stage;
        ex_mem <= id_ex;
        mem_wb <= ex_mem;
      end
    end
  end

  assign bus.pc_write        = pc_write;
  assign bus.if_id_write     = if_id_write;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.mem_req         = memop;
  assign bus.id_ex_rd        = id_ex.rd;
  assign bus.id_ex_memread   = id_ex.memread;
  assign bus.ex_mem_rd       = ex_mem.rd;
  assign bus.ex_mem_regwrite = ex_mem.regwrite;
  assign bus.mem_wb_rd       = mem_wb.rd;
  assign bus.mem_wb_regwrite = mem_wb.regwrite;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating: a wrapped count would read as a nearly idle pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((freeze | (load_use & ~bus.branch_taken)) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scoreboard bench for hazard_pipe_ctrl: directed scenarios then random traffic,
// expected per-cycle outputs queued by the stimulus and checked by a negedge monitor.
module tb_hazard_pipe_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int rd;
    bit rw;
    bit mr;
    bit mw;
  } instr_t;

  typedef struct {
    bit          pc_write;
    bit          if_id_write;
    bit          if_id_flush;
    bit          mem_req;
    int          id_ex_rd;
    bit          id_ex_memread;
    int          ex_mem_rd;
    bit          ex_mem_regwrite;
    int          mem_wb_rd;
    bit          mem_wb_regwrite;
    longint      stall;
  } exp_t;

  instr_t pipe [3];   // [0]=in EX, [1]=in MEM, [2]=in WB
  longint stall_model;
  exp_t   sb_q [$];
  int     total = 0;
  int     bad   = 0;

  function automatic instr_t nop();
    instr_t n;
    n.rd = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    return n;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model predicts what the DUT shows during this cycle
  // and then moves the tracked instructions as the pipeline rules dictate.
  task automatic cyc(input bit r, input int rs1, input int rs2, input int rd,
                     input bit rw, input bit mr, input bit mw, input bit bt, input bit rdy);
    bit   busy, hold, hazard;
    exp_t e;
    instr_t incoming;
    @(posedge clk);
    #1;
    rst              = r;
    bus.if_id_rs1    = REG_AW'(rs1);
    bus.if_id_rs2    = REG_AW'(rs2);
    bus.id_rd        = REG_AW'(rd);
    bus.id_regwrite  = rw;
    bus.id_memread   = mr;
    bus.id_memwrite  = mw;
    bus.branch_taken = bt;
    bus.mem_ready    = rdy;
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop();
      stall_model = 0;
    end else begin
      busy   = pipe[1].mr || pipe[1].mw;
      hold   = busy && !rdy;
      hazard = pipe[0].mr && pipe[0].rd != 0 && (pipe[0].rd == rs1 || pipe[0].rd == rs2);
      e.pc_write        = !hold && (bt || !hazard);
      e.if_id_write     = e.pc_write;
      e.if_id_flush     = !hold && bt;
      e.mem_req         = busy;
      e.id_ex_rd        = pipe[0].rd;
      e.id_ex_memread   = pipe[0].mr;
      e.ex_mem_rd       = pipe[1].rd;
      e.ex_mem_regwrite = pipe[1].rw;
      e.mem_wb_rd       = pipe[2].rd;
      e.mem_wb_regwrite = pipe[2].rw;
      e.stall           = stall_model;
      sb_q.push_back(e);
      if ((hold || (hazard && !bt)) && stall_model < 64'hFFFF_FFFF) stall_model++;
      if (!hold) begin
        incoming.rd = rd; incoming.rw = rw; incoming.mr = mr; incoming.mw = mw;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (bt || hazard) ? nop() : incoming;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Monitor: one expectation per non-reset cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_write",        bus.pc_write,        e.pc_write);
        chk("if_id_write",     bus.if_id_write,     e.if_id_write);
        chk("if_id_flush",     bus.if_id_flush,     e.if_id_flush);
        chk("mem_req",         bus.mem_req,         e.mem_req);
        chk("id_ex_rd",        bus.id_ex_rd,        e.id_ex_rd);
        chk("id_ex_memread",   bus.id_ex_memread,   e.id_ex_memread);
        chk("ex_mem_rd",       bus.ex_mem_rd,       e.ex_mem_rd);
        chk("ex_mem_regwrite", bus.ex_mem_regwrite, e.ex_mem_regwrite);
        chk("mem_wb_rd",       bus.mem_wb_rd,       e.mem_wb_rd);
        chk("mem_wb_regwrite", bus.mem_wb_regwrite, e.mem_wb_regwrite);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cycles",    bus.stall_cycles,    e.stall);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.if_id_rs1 = '0; bus.if_id_rs2 = '0; bus.id_rd = '0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.branch_taken = 0; bus.mem_ready = 1;
    for (int i = 0; i < 3; i++) pipe[i] = nop();
    stall_model = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // load x5, dependent use, then a store that waits three cycles on memory
    cyc(0, 0, 0, 5, 0, 1, 0, 0, 1);
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    idle(0);
    idle(0);
    idle(0);
    idle(1);
`ifdef HAZ_STALL_CNT_EN
    @(negedge clk);
    chk("stall_after_loaduse_and_wait", bus.stall_cycles, 4);
`endif
    idle(1);
    idle(1);

    // load to x0 with a reader of x0: no stall
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // branch in the same cycle as a load-use on rs2
    cyc(0, 0, 0, 3, 1, 1, 0, 0, 1);
    cyc(0, 1, 3, 9, 1, 0, 0, 1, 1);
    idle(1);
    idle(1);

    // plain rd=7 writer travels to WB in three cycles
    cyc(0, 0, 0, 7, 1, 0, 0, 0, 1);
    idle(1);
    idle(1);
    idle(1);
    idle(1);

    // reset in the middle of a memory wait, then a second reset in a load-use stall
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    idle(0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    idle(1);
    cyc(0, 0, 0, 4, 1, 1, 0, 0, 1);
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // random traffic over a small register set to provoke hazards often
    for (int n = 0; n < 600; n++) begin
      int  rd;
      bit  mr, mw;
      rd = int'($urandom_range(0, 3));
      mr = ($urandom_range(0, 3) == 0);
      mw = !mr && ($urandom_range(0, 4) == 0);
      cyc(($urandom_range(0, 199) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          rd, ($urandom_range(0, 1) == 1), mr, mw,
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) != 0));
    end
    idle(1);

    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
